// File: rtl/grant_scheduler_8.sv
// ---------------------------------------------------------------------------
// grant_scheduler_8
//
// Eight-way round-robin grant scheduler. One requester at a time owns a
// shared resource. The owner keeps it until it signals done or drops its
// request. After every release the bus sits idle for one cycle. Then the next
// requester in rotating priority order is granted.
//
// Optional feature (macro GRANT_TIMEOUT_EN):
//   When defined, a hold counter limits each grant to HOLD_MAX cycles. On a
//   forced release, timeout pulses for one cycle. When undefined, grants are
//   held indefinitely and timeout is tied low.
//
// Parameters:
//   HOLD_MAX   maximum cycles a grant may be held (2..255), timeout build only
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req[7:0]   request vector, bit i = requester i wants the resource
//   done       current grantee finished; only looked at while granting
//   gnt[7:0]   one-hot grant
//   gnt_idx    binary index of the current (or most recent) grantee
//   gnt_valid  high while a grant is active
//   timeout    one-cycle pulse when a grant is forcibly revoked
// ---------------------------------------------------------------------------
module grant_scheduler_8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic       pick_found;
  logic [2:0] pick_idx;
  logic [2:0] cand;
  logic       release_now;

  // Out-of-range hold limits are rejected at elaboration.
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_range
    $error("grant_scheduler_8: HOLD_MAX must be in 2..255");
  end

  // Rotating priority search. The scan runs from the lowest priority offset
  // to the highest. Each later hit overwrites an earlier one, so the
  // requester closest to ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    cand       = ptr;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // The owner gives the resource back either explicitly or by withdrawing its
  // request. Requests from other requesters are never looked at here.
  assign release_now = done | ~req[gnt_idx];

`ifdef GRANT_TIMEOUT_EN
  // The counter holds the number of completed grant cycles minus one at each
  // edge. When it equals HOLD_MAX-1, the current edge ends the HOLD_MAX-th
  // cycle.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_cnt;
  logic       hit_limit;

  assign hit_limit = (hold_cnt == HOLD_LAST);
`else
  assign timeout = 1'b0;
`endif

  // Scheduler FSM. All outputs are registered so that reset clears them
  // immediately. A normal release takes precedence over the hold limit, so a
  // release in the same cycle as the limit never reports a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      hold_cnt  <= 8'd0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef GRANT_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= GRANT;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            gnt       <= 8'h01 << pick_idx;
`ifdef GRANT_TIMEOUT_EN
            hold_cnt  <= 8'd0;
`endif
          end
        end

        GRANT: begin
          if (release_now) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt       <= 8'h00;
            ptr       <= gnt_idx + 3'd1;
          end
`ifdef GRANT_TIMEOUT_EN
          else if (hit_limit) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt       <= 8'h00;
            ptr       <= gnt_idx + 3'd1;
            timeout   <= 1'b1;
          end else begin
            hold_cnt  <= hold_cnt + 8'd1;
          end
`endif
        end

        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
          gnt       <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_scheduler_8.sv
// ---------------------------------------------------------------------------
// tb_grant_scheduler_8
//
// Self-checking bench for grant_scheduler_8 (HOLD_MAX = 4). A behavioural
// model describes the scheduler as "who owns the resource, for how many
// cycles, and whose turn is next". The bench compares the model against the
// DUT after every clock edge. Directed steps come first, then a randomized
// tail. The expected timeout behaviour follows GRANT_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_grant_scheduler_8;

  localparam int HOLD = 4;
`ifdef GRANT_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Model state: whether someone owns the resource, who, for how many cycles,
  // whose turn is first next time, and whether the last release was forced.
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_held;
  bit m_timeout;

  grant_scheduler_8 #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic int first_requester(input logic [7:0] r, input int p);
    for (int off = 0; off < 8; off++) begin
      if (r[(p + off) % 8]) return (p + off) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid   = 1'b0;
    m_idx     = 0;
    m_ptr     = 0;
    m_held    = 0;
    m_timeout = 1'b0;
  endtask

  // Advance the model across one clock edge with inputs r/d.
  task automatic model_step(input logic [7:0] r, input logic d);
    m_timeout = 1'b0;
    if (!m_valid) begin
      if (r != 8'h00) begin
        m_idx   = first_requester(r, m_ptr);
        m_valid = 1'b1;
        m_held  = 0;
      end
    end else begin
      m_held++;
      if (d || !r[m_idx]) begin
        m_valid = 1'b0;
        m_ptr   = (m_idx + 1) % 8;
      end else if (TIMEOUT_EN && m_held >= HOLD) begin
        m_valid   = 1'b0;
        m_ptr     = (m_idx + 1) % 8;
        m_timeout = 1'b1;
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string ctx);
    logic [7:0] exp_gnt;
    exp_gnt = m_valid ? 8'(1 << m_idx) : 8'h00;
    check_val({ctx, ".gnt"}, gnt, exp_gnt);
    check_val({ctx, ".gnt_idx"}, {5'd0, gnt_idx}, 8'(m_idx));
    check_val({ctx, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, m_valid});
    check_val({ctx, ".timeout"}, {7'd0, timeout}, {7'd0, m_timeout});
    check_val({ctx, ".onehot"}, {7'd0, $onehot0(gnt)}, 8'd1);
  endtask

  // Drive one cycle of inputs, step the model, and compare just after the edge.
  task automatic applyStimulus(input string ctx, input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    checkOutput(ctx);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;
    model_reset();

    $display("[TB] reset with all requests asserted");
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("reset");
    end
    rst = 1'b0;

    $display("[TB] fairness sweep with req=FF");
    for (int g = 0; g < 9; g++) begin
      applyStimulus("fair_grant", 8'hFF, 1'b0);
      check_val("fair_order", {5'd0, gnt_idx}, 8'(g % 8));
      applyStimulus("fair_release", 8'hFF, 1'b1);
      check_val("fair_gap", gnt, 8'h00);
    end

    $display("[TB] single requester and priority rotation");
    applyStimulus("single_grant", 8'h20, 1'b0);
    check_val("single_gnt5", gnt, 8'h20);
    applyStimulus("single_release", 8'h20, 1'b1);
    applyStimulus("rot_first", 8'h41, 1'b0);
    check_val("rot_first_idx6", {5'd0, gnt_idx}, 8'd6);
    applyStimulus("rot_release6", 8'h41, 1'b1);
    applyStimulus("rot_second", 8'h41, 1'b0);
    check_val("rot_second_idx0", {5'd0, gnt_idx}, 8'd0);
    applyStimulus("rot_release0", 8'h41, 1'b1);

    $display("[TB] no preemption, release on request drop");
    applyStimulus("nopre_grant", 8'h08, 1'b0);
    applyStimulus("nopre_others", 8'hFF, 1'b0);
    check_val("nopre_still3", gnt, 8'h08);
    applyStimulus("nopre_others2", 8'h0C, 1'b0);
    applyStimulus("nopre_drop", 8'h00, 1'b0);

    $display("[TB] long hold of requester 2");
    for (int c = 0; c < 22; c++) applyStimulus("hold", 8'h04, 1'b0);
    applyStimulus("hold_drop", 8'h00, 1'b0);
    applyStimulus("hold_idle", 8'h00, 1'b0);

    $display("[TB] done coinciding with the hold limit");
    applyStimulus("limit_grant", 8'h04, 1'b0);
    for (int c = 0; c < HOLD - 1; c++) applyStimulus("limit_hold", 8'h04, 1'b0);
    applyStimulus("limit_done", 8'h04, 1'b1);
    check_val("limit_no_timeout", {7'd0, timeout}, 8'd0);
    applyStimulus("limit_idle", 8'h00, 1'b0);

    $display("[TB] reset between edges during a grant");
    applyStimulus("mid_grant", 8'h80, 1'b0);
    check_val("mid_gnt7", gnt, 8'h80);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_async_gnt", gnt, 8'h00);
    check_val("mid_async_valid", {7'd0, gnt_valid}, 8'd0);
    model_reset();
    req = 8'hFF;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_hold");
    rst = 1'b0;
    applyStimulus("post_rst", 8'hFF, 1'b0);
    check_val("post_rst_idx0", {5'd0, gnt_idx}, 8'd0);
    applyStimulus("post_rst_release", 8'hFF, 1'b1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      logic       d;
      r = 8'($urandom);
      if ($urandom_range(0, 5) == 0) r = 8'h00;
      d = ($urandom_range(0, 3) == 0);
      applyStimulus("random", r, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
